// File: rtl/ctrl_pipe_stage_if.sv
// Purpose: handshake/bundle signals of one control pipeline register block.
// Latency: none (wiring only).
// Backpressure: stall is carried here; there is no ready return path.
// Ports (master = upstream/hazard unit, slave = ctrl_pipe_stage):
//   in_valid, in_ctrl, stall, flush, bubble   master -> slave
//   out_valid, out_ctrl, occupancy,
//   stall_cnt, flush_cnt                      slave -> master
interface ctrl_pipe_stage_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_ctrl;
    logic             stall;
    logic             flush;
    logic             bubble;
    logic             out_valid;
    logic [WIDTH-1:0] out_ctrl;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output in_valid, in_ctrl, stall, flush, bubble,
        input  out_valid, out_ctrl, occupancy, stall_cnt, flush_cnt
    );

    modport slave (
        input  in_valid, in_ctrl, stall, flush, bubble,
        output out_valid, out_ctrl, occupancy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// Purpose: DEPTH-stage control-bundle pipeline register with valid bits, stall/flush/bubble and saturating event counters.
// Latency: a valid entry reaches out_* DEPTH edges after it is presented, plus one edge per stalled edge.
// Backpressure: stall freezes every stage and ignores in_*; upstream must hold its own entry while stalling.
// Ports: clk, reset (async, active-high); pipe (slave modport) carries in_valid/in_ctrl/stall/flush/bubble
//   in and out_valid/out_ctrl (stage DEPTH-1), occupancy (valid-stage count), stall_cnt/flush_cnt out.
module ctrl_pipe_stage #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    ctrl_pipe_stage_if.slave pipe
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] ctrl_q [DEPTH];
    logic [WIDTH-1:0] ctrl_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic             stall_take;

    // flush outranks stall, so a stall only counts when no flush is present
    assign stall_take = pipe.stall & ~pipe.flush;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;

        if (pipe.flush) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_d[i] = RESET_VAL;
            end
        end else if (!pipe.stall) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                valid_d[i] = valid_q[i-1];
                ctrl_d[i]  = ctrl_q[i-1];
            end
            // Empty entries always carry RESET_VAL so a squashed slot can
            // never assert RegWrite/MemWrite downstream.
            if (pipe.bubble || !pipe.in_valid) begin
                valid_d[0] = 1'b0;
                ctrl_d[0]  = RESET_VAL;
            end else begin
                valid_d[0] = 1'b1;
                ctrl_d[0]  = pipe.in_ctrl;
            end
        end

        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_take && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (pipe.flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= RESET_VAL;
            end
            occ_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            occ_q       <= occ_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pipe.out_valid = valid_q[DEPTH-1];
    assign pipe.out_ctrl  = ctrl_q[DEPTH-1];
    assign pipe.occupancy = occ_q;
    assign pipe.stall_cnt = stall_cnt_q;
    assign pipe.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Purpose: self-checking bench for ctrl_pipe_stage at DEPTH=3, DEPTH=2 and DEPTH=1 (4-bit counters).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ctrl_pipe_stage;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_pipe_stage_if #(.WIDTH(16), .DEPTH(3), .CNT_W(16)) if_a ();
    ctrl_pipe_stage_if #(.WIDTH(16), .DEPTH(2), .CNT_W(16)) if_c ();
    ctrl_pipe_stage_if #(.WIDTH(16), .DEPTH(1), .CNT_W(4))  if_b ();

    ctrl_pipe_stage #(.WIDTH(16), .DEPTH(3), .RESET_VAL(16'h0000), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .pipe(if_a));
    ctrl_pipe_stage #(.WIDTH(16), .DEPTH(2), .RESET_VAL(16'h00FF), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .pipe(if_c));
    ctrl_pipe_stage #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'hDEAD), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .pipe(if_b));

    typedef struct {
        int          iv;
        logic [15:0] ictrl;
        int          st;
        int          fl;
        int          bu;
        int          ev;
        logic [15:0] ectrl;
        int          eocc;
        int          esc;
        int          efc;
    } vec_t;

    vec_t vec [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int iv, input logic [15:0] c, input int st, input int fl, input int bu);
        if_a.in_valid = iv[0];
        if_a.in_ctrl  = c;
        if_a.stall    = st[0];
        if_a.flush    = fl[0];
        if_a.bubble   = bu[0];
    endtask

    task automatic drive_b(input int iv, input logic [15:0] c, input int st, input int fl, input int bu);
        if_b.in_valid = iv[0];
        if_b.in_ctrl  = c;
        if_b.stall    = st[0];
        if_b.flush    = fl[0];
        if_b.bubble   = bu[0];
    endtask

    task automatic drive_c(input int iv, input logic [15:0] c, input int st, input int fl, input int bu);
        if_c.in_valid = iv[0];
        if_c.in_ctrl  = c;
        if_c.stall    = st[0];
        if_c.flush    = fl[0];
        if_c.bubble   = bu[0];
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // DEPTH=3 vectors: {iv, in_ctrl, stall, flush, bubble, exp valid, exp ctrl, exp occ, exp stall_cnt, exp flush_cnt}
        vec[0]  = '{1, 16'h0011, 0, 0, 0, 0, 16'h0000, 1, 0, 0};
        vec[1]  = '{1, 16'h0022, 0, 0, 0, 0, 16'h0000, 2, 0, 0};
        vec[2]  = '{1, 16'h0033, 0, 0, 0, 1, 16'h0011, 3, 0, 0};
        vec[3]  = '{1, 16'h0044, 0, 0, 1, 1, 16'h0022, 2, 0, 0};
        vec[4]  = '{0, 16'h0055, 0, 0, 0, 1, 16'h0033, 1, 0, 0};
        vec[5]  = '{1, 16'h0066, 0, 0, 0, 0, 16'h0000, 1, 0, 0};
        vec[6]  = '{1, 16'h0077, 1, 0, 1, 0, 16'h0000, 1, 1, 0};
        vec[7]  = '{1, 16'h0088, 0, 0, 0, 0, 16'h0000, 2, 1, 0};
        vec[8]  = '{1, 16'h0099, 1, 1, 0, 0, 16'h0000, 0, 1, 1};
        vec[9]  = '{1, 16'h00A0, 0, 0, 0, 0, 16'h0000, 1, 1, 1};
        vec[10] = '{1, 16'h00AA, 0, 0, 0, 0, 16'h0000, 2, 1, 1};
        vec[11] = '{1, 16'h00BB, 0, 1, 0, 0, 16'h0000, 0, 1, 2};
        vec[12] = '{0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 2};
        vec[13] = '{1, 16'h0101, 0, 0, 0, 0, 16'h0000, 1, 1, 2};
        vec[14] = '{1, 16'h0202, 0, 0, 0, 0, 16'h0000, 2, 1, 2};
        vec[15] = '{1, 16'h0303, 0, 0, 0, 1, 16'h0101, 3, 1, 2};
        vec[16] = '{1, 16'h0404, 1, 0, 0, 1, 16'h0101, 3, 2, 2};
        vec[17] = '{0, 16'h0000, 0, 0, 0, 1, 16'h0202, 2, 2, 2};
        vec[18] = '{0, 16'h0000, 0, 0, 0, 1, 16'h0303, 1, 2, 2};
        vec[19] = '{0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 2, 2};

        reset = 1'b0;
        drive_a(0, 16'h0000, 0, 0, 0);
        drive_b(0, 16'h0000, 0, 0, 0);
        drive_c(0, 16'h0000, 0, 0, 0);

        // asynchronous reset, checked before any clock edge
        #1 reset = 1'b1;
        #2;
        chk("rst a out_valid", 32'(if_a.out_valid), 0);
        chk("rst a out_ctrl",  32'(if_a.out_ctrl), 32'h0000);
        chk("rst a occupancy", 32'(if_a.occupancy), 0);
        chk("rst a stall_cnt", 32'(if_a.stall_cnt), 0);
        chk("rst a flush_cnt", 32'(if_a.flush_cnt), 0);
        chk("rst b out_ctrl",  32'(if_b.out_ctrl), 32'hDEAD);
        chk("rst c out_ctrl",  32'(if_c.out_ctrl), 32'h00FF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // DEPTH=3 table
        for (int i = 0; i < 20; i++) begin
            drive_a(vec[i].iv, vec[i].ictrl, vec[i].st, vec[i].fl, vec[i].bu);
            tick();
            chk($sformatf("vec%0d out_valid", i), 32'(if_a.out_valid), vec[i].ev);
            chk($sformatf("vec%0d out_ctrl", i),  32'(if_a.out_ctrl),  32'(vec[i].ectrl));
            chk($sformatf("vec%0d occupancy", i), 32'(if_a.occupancy), vec[i].eocc);
            chk($sformatf("vec%0d stall_cnt", i), 32'(if_a.stall_cnt), vec[i].esc);
            chk($sformatf("vec%0d flush_cnt", i), 32'(if_a.flush_cnt), vec[i].efc);
        end

        // DEPTH=2: stall holds the pipe, then the older entry emerges
        drive_c(1, 16'h0002, 0, 0, 0);
        tick();
        drive_c(1, 16'h0001, 0, 0, 0);
        tick();
        chk("c fill out_ctrl", 32'(if_c.out_ctrl), 32'h0002);
        chk("c fill occupancy", 32'(if_c.occupancy), 2);
        drive_c(1, 16'h0003, 1, 0, 0);
        tick();
        chk("c stall1 out_ctrl", 32'(if_c.out_ctrl), 32'h0002);
        chk("c stall1 stall_cnt", 32'(if_c.stall_cnt), 1);
        tick();
        chk("c stall2 out_ctrl", 32'(if_c.out_ctrl), 32'h0002);
        chk("c stall2 out_valid", 32'(if_c.out_valid), 1);
        chk("c stall2 stall_cnt", 32'(if_c.stall_cnt), 2);
        chk("c stall2 occupancy", 32'(if_c.occupancy), 2);
        drive_c(0, 16'h0000, 0, 0, 0);
        tick();
        chk("c release out_ctrl", 32'(if_c.out_ctrl), 32'h0001);
        chk("c release out_valid", 32'(if_c.out_valid), 1);
        chk("c release occupancy", 32'(if_c.occupancy), 1);
        tick();
        chk("c drain out_valid", 32'(if_c.out_valid), 0);
        chk("c drain out_ctrl", 32'(if_c.out_ctrl), 32'h00FF);

        // DEPTH=1: load, count one flush and one stall, then reset between edges
        drive_b(1, 16'hA5A5, 0, 0, 0);
        tick();
        chk("b load out_valid", 32'(if_b.out_valid), 1);
        chk("b load out_ctrl", 32'(if_b.out_ctrl), 32'hA5A5);
        chk("b load occupancy", 32'(if_b.occupancy), 1);
        drive_b(1, 16'h1111, 0, 1, 0);
        tick();
        chk("b flush out_ctrl", 32'(if_b.out_ctrl), 32'hDEAD);
        chk("b flush flush_cnt", 32'(if_b.flush_cnt), 1);
        drive_b(1, 16'h2222, 1, 0, 0);
        tick();
        chk("b stall out_ctrl", 32'(if_b.out_ctrl), 32'hDEAD);
        chk("b stall stall_cnt", 32'(if_b.stall_cnt), 1);
        drive_b(1, 16'hA5A5, 0, 0, 0);
        tick();
        chk("b reload out_ctrl", 32'(if_b.out_ctrl), 32'hA5A5);
        #2 reset = 1'b1;
        #1;
        chk("b midrst out_valid", 32'(if_b.out_valid), 0);
        chk("b midrst out_ctrl", 32'(if_b.out_ctrl), 32'hDEAD);
        chk("b midrst occupancy", 32'(if_b.occupancy), 0);
        chk("b midrst stall_cnt", 32'(if_b.stall_cnt), 0);
        chk("b midrst flush_cnt", 32'(if_b.flush_cnt), 0);
        reset = 1'b0;

        // DEPTH=1: bubble acts as advance with in_valid=0
        drive_b(1, 16'h5555, 0, 0, 0);
        tick();
        chk("b pre-bubble out_ctrl", 32'(if_b.out_ctrl), 32'h5555);
        drive_b(1, 16'h7777, 0, 0, 1);
        tick();
        chk("b bubble out_valid", 32'(if_b.out_valid), 0);
        chk("b bubble out_ctrl", 32'(if_b.out_ctrl), 32'hDEAD);
        drive_b(1, 16'h5555, 0, 0, 0);
        tick();
        drive_b(0, 16'h1234, 0, 0, 0);
        tick();
        chk("b invalid out_valid", 32'(if_b.out_valid), 0);
        chk("b invalid out_ctrl", 32'(if_b.out_ctrl), 32'hDEAD);

        // 4-bit counters saturate at 15
        drive_b(0, 16'h0000, 1, 0, 0);
        repeat (14) tick();
        chk("b stall14 stall_cnt", 32'(if_b.stall_cnt), 14);
        repeat (6) tick();
        chk("b stall20 stall_cnt", 32'(if_b.stall_cnt), 15);
        drive_b(0, 16'h0000, 0, 1, 0);
        repeat (17) tick();
        chk("b flush17 flush_cnt", 32'(if_b.flush_cnt), 15);
        chk("b flush17 stall_cnt", 32'(if_b.stall_cnt), 15);
        drive_b(0, 16'h0000, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
